// File: rtl/icache_pkg.sv
// Shared types and helpers for the instruction-cache refill path.
package icache_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMreq = 2'd1,
    StRecv = 2'd2,
    StFill = 2'd3
  } refill_state_e;

  localparam logic RD_TYPE_WORD = 1'b0;
  localparam logic RD_TYPE_LINE = 1'b1;

  localparam int unsigned OFFSET_WIDTH_DEF = 2;
  localparam int unsigned LINE_WORDS       = 1 << OFFSET_WIDTH_DEF;

  function automatic int unsigned line_words(input int unsigned offset_width);
    return 1 << offset_width;
  endfunction

  // Clears the byte offset plus the word-within-line offset.
  function automatic logic [31:0] line_align(input logic [31:0] addr,
                                             input int unsigned offset_width);
    logic [31:0] mask;
    mask = ~((32'd1 << (offset_width + 2)) - 32'd1);
    return addr & mask;
  endfunction

endpackage

// File: rtl/icache_line_buf.sv
// Refill line buffer: beat counter, per-word storage and a word-select read port.
module icache_line_buf
  import icache_pkg::*;
#(
  parameter int unsigned offset_width = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clr,
  input  logic                                  we,
  input  logic [31:0]                           wdata,
  input  logic [offset_width-1:0]               rd_sel,
  output logic [31:0]                           rd_data,
  output logic [32*(1<<offset_width)-1:0]       line
);

  localparam int unsigned LineWords = 1 << offset_width;

  logic [31:0]             words_q [LineWords];
  logic [offset_width-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      for (int i = 0; i < LineWords; i++) begin
        words_q[i] <= '0;
      end
    end else if (clr) begin
      cnt_q <= '0;
    end else if (we) begin
      words_q[cnt_q] <= wdata;
      // Wraps naturally modulo the line length.
      cnt_q          <= cnt_q + offset_width'(1);
    end
  end

  assign rd_data = words_q[rd_sel];

  always_comb begin
    line = '0;
    for (int i = 0; i < LineWords; i++) begin
      line[32*i +: 32] = words_q[i];
    end
  end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Stage-2 instruction-cache miss/refill controller: hit return, line refill and
// single-word uncached fetch, stalling the request buffer while busy.
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int unsigned offset_width = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             rbuf_valid,
  input  logic [31:0]                      rbuf_addr,
  input  logic [31:0]                      rbuf_paddr,
  input  logic                             rbuf_opflag,
  input  logic                             rbuf_SUC,
  input  logic                             hit,
  input  logic [31:0]                      hit_data,
  input  logic                             flush,
  output logic                             rbuf_stall,
  output logic                             data_valid,
  output logic [31:0]                      data_out,
  output logic                             mem_rd_req,
  output logic                             mem_rd_type,
  output logic [31:0]                      mem_rd_addr,
  input  logic                             mem_rd_rdy,
  input  logic                             mem_ret_valid,
  input  logic                             mem_ret_last,
  input  logic [31:0]                      mem_ret_data,
  output logic                             refill_we,
  output logic [31:0]                      refill_addr,
  output logic [32*(1<<offset_width)-1:0]  refill_data
);

  refill_state_e state_q, state_d;
  logic          suc_q, suc_d;
  logic          cancel_q, cancel_d;
  logic [31:0]   paddr_q, paddr_d;
  logic [31:0]   vaddr_q, vaddr_d;

  logic          active, miss;
  logic          lb_clr, lb_we;
  logic [31:0]   lb_rd_data;

  assign active = rbuf_valid & ~rbuf_opflag;
  assign miss   = active & (rbuf_SUC | ~hit);

  icache_line_buf #(
    .offset_width(offset_width)
  ) u_line_buf (
    .clk     (clk),
    .rst     (rst),
    .clr     (lb_clr),
    .we      (lb_we),
    .wdata   (mem_ret_data),
    .rd_sel  (paddr_q[offset_width+1:2]),
    .rd_data (lb_rd_data),
    .line    (refill_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      suc_q    <= 1'b0;
      cancel_q <= 1'b0;
      paddr_q  <= '0;
      vaddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      suc_q    <= suc_d;
      cancel_q <= cancel_d;
      paddr_q  <= paddr_d;
      vaddr_q  <= vaddr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    suc_d       = suc_q;
    cancel_d    = cancel_q;
    paddr_d     = paddr_q;
    vaddr_d     = vaddr_q;
    lb_clr      = 1'b0;
    lb_we       = 1'b0;
    rbuf_stall  = 1'b0;
    data_valid  = 1'b0;
    data_out    = '0;
    mem_rd_req  = 1'b0;
    mem_rd_type = RD_TYPE_WORD;
    mem_rd_addr = '0;
    refill_we   = 1'b0;
    refill_addr = '0;

    unique case (state_q)
      StIdle: begin
        if (active && !rbuf_SUC && hit) begin
          data_valid = 1'b1;
          data_out   = hit_data;
        end
        if (miss) begin
          rbuf_stall = 1'b1;
          if (!flush) begin
            state_d = StMreq;
            suc_d   = rbuf_SUC;
            paddr_d = rbuf_paddr;
            vaddr_d = rbuf_addr;
          end
        end
      end
      StMreq: begin
        rbuf_stall = 1'b1;
        mem_rd_req = 1'b1;
        if (suc_q) begin
          mem_rd_type = RD_TYPE_WORD;
          mem_rd_addr = {paddr_q[31:2], 2'b00};
        end else begin
          mem_rd_type = RD_TYPE_LINE;
          mem_rd_addr = line_align(paddr_q, offset_width);
        end
        // Once accepted the transaction must complete, so a coincident flush only cancels.
        if (mem_rd_rdy) begin
          state_d = StRecv;
          lb_clr  = 1'b1;
          if (flush) cancel_d = 1'b1;
        end else if (flush) begin
          state_d = StIdle;
        end
      end
      StRecv: begin
        rbuf_stall = 1'b1;
        if (flush) cancel_d = 1'b1;
        if (mem_ret_valid) begin
          lb_we = 1'b1;
          if (mem_ret_last) begin
            if (suc_q) begin
              state_d = StIdle;
              if (!cancel_q && !flush) begin
                data_valid = 1'b1;
                data_out   = mem_ret_data;
              end
            end else begin
              state_d = StFill;
            end
          end
        end
      end
      StFill: begin
        refill_we   = 1'b1;
        refill_addr = line_align(vaddr_q, offset_width);
        state_d     = StIdle;
        if (!cancel_q && !flush) begin
          data_valid = 1'b1;
          data_out   = lb_rd_data;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StIdle) cancel_d = 1'b0;
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed self-checking bench for icache_refill_ctrl (offset_width = 2).
module tb_icache_refill_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         rbuf_valid, rbuf_opflag, rbuf_SUC, hit, flush;
  logic [31:0]  rbuf_addr, rbuf_paddr, hit_data;
  logic         rbuf_stall, data_valid;
  logic [31:0]  data_out;
  logic         mem_rd_req, mem_rd_type;
  logic [31:0]  mem_rd_addr;
  logic         mem_rd_rdy, mem_ret_valid, mem_ret_last;
  logic [31:0]  mem_ret_data;
  logic         refill_we;
  logic [31:0]  refill_addr;
  logic [127:0] refill_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  icache_refill_ctrl #(
    .offset_width(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rbuf_valid    (rbuf_valid),
    .rbuf_addr     (rbuf_addr),
    .rbuf_paddr    (rbuf_paddr),
    .rbuf_opflag   (rbuf_opflag),
    .rbuf_SUC      (rbuf_SUC),
    .hit           (hit),
    .hit_data      (hit_data),
    .flush         (flush),
    .rbuf_stall    (rbuf_stall),
    .data_valid    (data_valid),
    .data_out      (data_out),
    .mem_rd_req    (mem_rd_req),
    .mem_rd_type   (mem_rd_type),
    .mem_rd_addr   (mem_rd_addr),
    .mem_rd_rdy    (mem_rd_rdy),
    .mem_ret_valid (mem_ret_valid),
    .mem_ret_last  (mem_ret_last),
    .mem_ret_data  (mem_ret_data),
    .refill_we     (refill_we),
    .refill_addr   (refill_addr),
    .refill_data   (refill_data)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the edge; outputs are checked mid-cycle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic mem_idle();
    mem_rd_rdy    = 1'b0;
    mem_ret_valid = 1'b0;
    mem_ret_last  = 1'b0;
    mem_ret_data  = '0;
  endtask

  task automatic beat(input logic [31:0] d, input logic last);
    mem_ret_valid = 1'b1;
    mem_ret_last  = last;
    mem_ret_data  = d;
  endtask

  task automatic req(input logic [31:0] va, input logic [31:0] pa, input logic suc);
    rbuf_valid = 1'b1;
    rbuf_addr  = va;
    rbuf_paddr = pa;
    rbuf_SUC   = suc;
    hit        = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_stall"}, rbuf_stall, 1'b0);
    check({tag, "_req"}, mem_rd_req, 1'b0);
    check({tag, "_dv"}, data_valid, 1'b0);
    check({tag, "_we"}, refill_we, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rbuf_valid = 0; rbuf_opflag = 0; rbuf_SUC = 0; hit = 0; flush = 0;
    rbuf_addr = '0; rbuf_paddr = '0; hit_data = '0;
    mem_idle();
    next_cycle();
    next_cycle();
    rst = 1'b0;

    // Reset state
    settle();
    check_idle("rst");
    check("rst_line", refill_data, 128'h0);
    check("rst_dout", data_out, 32'h0);
    next_cycle();

    // Hit: same-cycle return
    rbuf_valid = 1; hit = 1; hit_data = 32'h0280_0000;
    settle();
    check("hit_dv", data_valid, 1'b1);
    check("hit_dout", data_out, 32'h0280_0000);
    check("hit_stall", rbuf_stall, 1'b0);
    check("hit_req", mem_rd_req, 1'b0);
    next_cycle();

    // Cache-op is ignored even on a tag miss
    rbuf_opflag = 1; hit = 0;
    settle();
    check("op_stall", rbuf_stall, 1'b0);
    check("op_dv", data_valid, 1'b0);
    next_cycle();
    rbuf_opflag = 0;

    // Cached miss, critical word at offset 2
    req(32'h0040_1238, 32'h1C00_0008, 1'b0);
    settle();
    check("cm_stall_t", rbuf_stall, 1'b1);
    check("cm_req_t", mem_rd_req, 1'b0);
    next_cycle();
    mem_rd_rdy = 1;
    settle();
    check("cm_req", mem_rd_req, 1'b1);
    check("cm_type", mem_rd_type, 1'b1);
    check("cm_addr", mem_rd_addr, 32'h1C00_0000);
    next_cycle();
    mem_idle();
    for (int i = 0; i < 4; i++) begin
      beat(32'hA0 + i, i == 3);
      settle();
      check("cm_recv_stall", rbuf_stall, 1'b1);
      check("cm_recv_dv", data_valid, 1'b0);
      next_cycle();
    end
    mem_idle();
    settle();
    check("cm_we", refill_we, 1'b1);
    check("cm_line", refill_data, 128'h0000_00A3_0000_00A2_0000_00A1_0000_00A0);
    check("cm_raddr", refill_addr, 32'h0040_1230);
    check("cm_dv", data_valid, 1'b1);
    check("cm_dout", data_out, 32'h0000_00A2);
    check("cm_fill_stall", rbuf_stall, 1'b0);
    next_cycle();
    rbuf_valid = 0;
    settle();
    check_idle("cm_after");
    next_cycle();

    // Uncached single word
    req(32'h0000_01E2, 32'h1FE0_01E2, 1'b1);
    hit = 1;
    settle();
    check("uc_stall_t", rbuf_stall, 1'b1);
    check("uc_dv_t", data_valid, 1'b0);
    next_cycle();
    mem_rd_rdy = 1;
    settle();
    check("uc_req", mem_rd_req, 1'b1);
    check("uc_type", mem_rd_type, 1'b0);
    check("uc_addr", mem_rd_addr, 32'h1FE0_01E0);
    next_cycle();
    mem_idle();
    beat(32'h1234_5678, 1'b1);
    settle();
    check("uc_dv", data_valid, 1'b1);
    check("uc_dout", data_out, 32'h1234_5678);
    check("uc_we", refill_we, 1'b0);
    next_cycle();
    mem_idle();
    rbuf_valid = 0; rbuf_SUC = 0;
    settle();
    check_idle("uc_after");
    next_cycle();

    // Delayed acceptance and bubbles between beats, critical word at offset 1
    req(32'h0000_0104, 32'h2000_0004, 1'b0);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      settle();
      check("dl_req_wait", mem_rd_req, 1'b1);
      check("dl_addr_wait", mem_rd_addr, 32'h2000_0000);
      check("dl_stall_wait", rbuf_stall, 1'b1);
      next_cycle();
    end
    mem_rd_rdy = 1;
    settle();
    check("dl_req_acc", mem_rd_req, 1'b1);
    next_cycle();
    mem_idle();
    for (int i = 0; i < 7; i++) begin
      if (i % 2 == 0) beat(32'hB0 + i / 2, i == 6);
      else mem_idle();
      settle();
      check("dl_recv_stall", rbuf_stall, 1'b1);
      check("dl_recv_req", mem_rd_req, 1'b0);
      next_cycle();
    end
    mem_idle();
    settle();
    check("dl_we", refill_we, 1'b1);
    check("dl_line", refill_data, 128'h0000_00B3_0000_00B2_0000_00B1_0000_00B0);
    check("dl_dout", data_out, 32'h0000_00B1);
    check("dl_stall_fill", rbuf_stall, 1'b0);
    next_cycle();
    rbuf_valid = 0;

    // Flush during RECV: drain, refill, no data_valid
    req(32'h0000_0000, 32'h3000_0000, 1'b0);
    next_cycle();
    mem_rd_rdy = 1;
    next_cycle();
    mem_idle();
    beat(32'hC0, 1'b0);
    next_cycle();
    beat(32'hC1, 1'b0);
    next_cycle();
    mem_idle();
    flush = 1; rbuf_valid = 0;
    next_cycle();
    flush = 0;
    beat(32'hC2, 1'b0);
    next_cycle();
    beat(32'hC3, 1'b1);
    settle();
    check("fr_stall", rbuf_stall, 1'b1);
    next_cycle();
    mem_idle();
    settle();
    check("fr_we", refill_we, 1'b1);
    check("fr_dv", data_valid, 1'b0);
    check("fr_line", refill_data, 128'h0000_00C3_0000_00C2_0000_00C1_0000_00C0);
    next_cycle();
    settle();
    check_idle("fr_after");
    next_cycle();

    // Flush in MREQ before acceptance
    req(32'h0, 32'h4000_0000, 1'b0);
    next_cycle();
    flush = 1;
    settle();
    check("fm_req", mem_rd_req, 1'b1);
    next_cycle();
    flush = 0; rbuf_valid = 0;
    settle();
    check_idle("fm_after");
    next_cycle();

    // Flush coincident with the miss
    req(32'h0, 32'h5000_0000, 1'b0);
    flush = 1;
    settle();
    check("fi_stall", rbuf_stall, 1'b1);
    next_cycle();
    flush = 0; rbuf_valid = 0;
    settle();
    check_idle("fi_after");
    next_cycle();

    // Reset in the middle of RECV
    req(32'h0, 32'h6000_0000, 1'b0);
    next_cycle();
    mem_rd_rdy = 1;
    next_cycle();
    mem_idle();
    beat(32'hD0, 1'b0);
    next_cycle();
    mem_idle();
    settle();
    check("rr_stall_pre", rbuf_stall, 1'b1);
    rst = 1;
    next_cycle();
    rst = 0; rbuf_valid = 0;
    settle();
    check_idle("rr_after");
    check("rr_line", refill_data, 128'h0);
    check("rr_addr", mem_rd_addr, 32'h0);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache_refill_ctrl.md
# icache_refill_ctrl

Stage-2 miss/refill controller of the instruction cache, directly downstream of the request buffer. It consumes the buffered request (virtual address, physical address, cache-op flag, uncached flag) and the tag-compare result. On a hit it returns the fetched word. On a cached miss it fetches the full line over the memory read port, writes it to the data/tag arrays and returns the critical word. On an uncached (SUC) access it fetches a single word. It stalls the request buffer while a transaction is in flight.

## Interface
Parameters:
- offset_width, 2, log2 of words per line; LINE_WORDS = 2^offset_width, line = 32*LINE_WORDS bits

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- rbuf_valid  in  1  stage-2 request present
- rbuf_addr  in  32  virtual fetch address (index for refill)
- rbuf_paddr  in  32  physical fetch address
- rbuf_opflag  in  1  cache-op request; ignored by this block (no stall, no data_valid)
- rbuf_SUC  in  1  strongly-ordered uncached access
- hit  in  1  tag compare hit for current request
- hit_data  in  32  word selected from the hit way
- flush  in  1  pipeline flush; cancels the current request
- rbuf_stall  out  1  freeze request buffer
- data_valid  out  1  data_out is the instruction for the current request
- data_out  out  32  returned instruction
- mem_rd_req  out  1  read request valid
- mem_rd_type  out  1  0 = single word, 1 = full line
- mem_rd_addr  out  32  request address
- mem_rd_rdy  in  1  request accepted this cycle
- mem_ret_valid  in  1  return beat valid
- mem_ret_last  in  1  final beat
- mem_ret_data  in  32  return beat data
- refill_we  out  1  write line into arrays
- refill_addr  out  32  {rbuf_addr index, offset zeroed}
- refill_data  out  32*LINE_WORDS  assembled line, word 0 in LSBs

## Operation
- States: IDLE, MREQ, RECV, FILL.
- A request is active when rbuf_valid & ~rbuf_opflag. miss = active & (rbuf_SUC | ~hit).
- IDLE
  - On active & ~rbuf_SUC & hit: data_valid=1, data_out=hit_data (combinational). Stay in IDLE.
  - On miss: rbuf_stall=1 combinationally. If ~flush, go to MREQ and latch the uncached flag.
- MREQ: mem_rd_req=1.
  - Uncached: mem_rd_type=0, mem_rd_addr=paddr with bits[1:0] zeroed.
  - Cached: mem_rd_type=1, mem_rd_addr=paddr with low offset_width+2 bits zeroed.
  - On mem_rd_rdy: go to RECV with beat counter=0.
  - flush before acceptance: go to IDLE with no memory transaction.
- RECV: each mem_ret_valid writes mem_ret_data into linebuf[cnt], then cnt++ (mod LINE_WORDS).
  - On the mem_ret_valid & mem_ret_last beat:
    - Uncached: data_valid=1, data_out=mem_ret_data (unless cancelled), then go to IDLE.
    - Cached: go to FILL.
- FILL, one cycle:
  - refill_we=1.
  - data_valid=1, data_out=linebuf[paddr[offset_width+1:2]] (unless cancelled).
  - rbuf_stall=0, go to IDLE.
- flush in RECV/FILL sets a cancel flag. Beats are still drained and the cached refill is still written, but data_valid is suppressed. The cancel flag clears on return to IDLE.
- rbuf_stall=1 in MREQ and RECV. rbuf_stall=0 in FILL and in IDLE unless a miss is detected.

## Timing
- Reset values: state=IDLE, cnt=0, cancel=0, linebuf=0. All outputs 0 except those combinational from inputs in IDLE.
- Hit: data_valid in the same cycle as rbuf_valid&hit; zero added latency.
- Cached miss:
  - Miss detected at cycle t; mem_rd_req from t+1.
  - With rdy at t+1 and back-to-back beats at t+2..t+1+LINE_WORDS, FILL/data_valid occurs at t+2+LINE_WORDS.
- Uncached: data_valid on the last-beat cycle, with rdy at t+1 and the beat at t+2.
- mem_rd_req and mem_rd_addr stay stable until mem_rd_rdy.
- Bubbles between beats are allowed. The counter advances only on mem_ret_valid.
- flush simultaneous with a miss in IDLE: no transaction starts.
- rst mid-RECV returns to IDLE immediately. Outstanding beats are the memory side's responsibility.

## Structure
- Package icache_pkg holds:
  - state enum (IDLE, MREQ, RECV, FILL)
  - RD_TYPE_WORD=0, RD_TYPE_LINE=1
  - LINE_WORDS and the offset-field helper derived from offset_width
- Sub-module icache_line_buf: beat counter plus linebuf register array, with write-enable, clear, and word-select read port.

## Test plan
- Hit: rbuf_valid=1, hit=1, hit_data=0x02800000 -> same-cycle data_valid=1, data_out=0x02800000, rbuf_stall=0, mem_rd_req=0.
- Cached miss, offset_width=2, paddr=0x1C000008, beats 0xA0..0xA3:
  - mem_rd_addr=0x1C000000, type=1.
  - refill_we for one cycle with refill_data={0xA3,0xA2,0xA1,0xA0}.
  - data_out=0xA2.
- Uncached, rbuf_SUC=1, paddr=0x1FE001E2, beat 0x12345678 -> mem_rd_addr=0x1FE001E0, type=0, data_valid with 0x12345678, refill_we never set.
- Delays: mem_rd_rdy held low 3 cycles, then one idle cycle between beats -> request and address stable throughout, correct line assembled, stall held until FILL.
- Flush in RECV after beat 1 -> remaining beats drained, refill_we=1, data_valid=0, IDLE afterwards.
- Flush in MREQ before rdy -> IDLE next cycle, no request accepted. rst during RECV -> all outputs 0, state IDLE.
